// File: rtl/uart_line_echo.sv
`default_nettype none
// ============================================================================
// Module  : uart_line_echo
// Brief   : Buffers one line of received bytes, then replays it (optionally
//           followed by CR/LF) to a byte transmitter over valid/ready.
// Revision: 1.0 - initial release
// ============================================================================
module uart_line_echo #(
  parameter int         MAX_LEN        = 128,
  parameter logic [7:0] TERM_CHAR      = 8'h0A,
  parameter bit         STRIP_CR       = 1'b1,
  parameter bit         APPEND_CRLF    = 1'b1,
  parameter int         TIMEOUT_CYCLES = 0,
  localparam int        LEN_W          = $clog2(MAX_LEN + 1)
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [7:0]       last_rx_byte,
  output logic [LEN_W-1:0] line_len,
  output logic             busy,
  output logic             line_done,
  output logic             overflow,
  output logic             rx_drop
);

  localparam int               c_AW  = $clog2(MAX_LEN);
  localparam logic [LEN_W-1:0] c_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] c_ONE = LEN_W'(1);

  typedef enum logic [2:0] {
    S_COLLECT = 3'd0,
    S_LOAD    = 3'd1,
    S_SEND    = 3'd2,
    S_CR      = 3'd3,
    S_LF      = 3'd4
  } state_t;

  state_t           r_state;
  logic [7:0]       r_buf [MAX_LEN];
  logic [7:0]       r_rd_data;
  logic [LEN_W-1:0] r_wr_ptr;
  logic [LEN_W-1:0] r_rd_ptr;
  logic             w_xfer;
  logic             w_last_payload;
  logic             w_is_cr;
  logic             w_store;
  logic             w_rd_en;
  logic [c_AW-1:0]  w_rd_addr;
  logic             w_timeout;

  assign w_xfer         = tx_valid & tx_ready;
  assign w_last_payload = (r_rd_ptr == r_wr_ptr);
  assign w_is_cr        = STRIP_CR && (rx_data == 8'h0D);
  assign w_store        = (r_state == S_COLLECT) && rx_valid && (rx_data != TERM_CHAR)
                          && !w_is_cr && (r_wr_ptr < c_MAX);
  assign w_rd_en        = ((r_state == S_LOAD) && (r_wr_ptr != '0))
                          || ((r_state == S_SEND) && w_xfer && !w_last_payload);
  assign w_rd_addr      = (r_state == S_LOAD) ? '0 : r_rd_ptr[c_AW-1:0];

  // Line RAM: no reset so it maps onto block RAM; read data only advances on a transfer.
  always_ff @(posedge sys_clk) begin
    if (w_store) r_buf[r_wr_ptr[c_AW-1:0]] <= rx_data;
    if (w_rd_en) r_rd_data <= r_buf[w_rd_addr];
  end

  always_comb begin
    tx_data = 8'h00;
    case (r_state)
      S_SEND:  tx_data = r_rd_data;
      S_CR:    tx_data = 8'h0D;
      S_LF:    tx_data = 8'h0A;
      default: tx_data = 8'h00;
    endcase
  end

  assign busy      = (r_state != S_COLLECT);
  assign line_done = w_xfer && ((r_state == S_LF)
                     || ((r_state == S_SEND) && !APPEND_CRLF && w_last_payload));

  if (TIMEOUT_CYCLES > 0) begin : g_timeout
    localparam int              c_TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TW-1:0] c_TLAST = c_TW'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TW-1:0] c_TONE  = c_TW'(1);
    logic [c_TW-1:0] r_cnt;
    logic            w_armed;

    // An arriving byte always wins over an expiring timer.
    assign w_armed   = (r_state == S_COLLECT) && (r_wr_ptr != '0) && !rx_valid;
    assign w_timeout = w_armed && (r_cnt == c_TLAST);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst)                           r_cnt <= '0;
      else if (!w_armed || r_cnt == c_TLAST) r_cnt <= '0;
      else                                   r_cnt <= r_cnt + c_TONE;
    end
  end else begin : g_no_timeout
    assign w_timeout = 1'b0;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state      <= S_COLLECT;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      tx_valid     <= 1'b0;
      line_len     <= '0;
      last_rx_byte <= 8'h00;
      overflow     <= 1'b0;
      rx_drop      <= 1'b0;
    end else begin
      overflow <= 1'b0;
      rx_drop  <= rx_valid && (r_state != S_COLLECT);
      if (rx_valid) last_rx_byte <= rx_data;

      case (r_state)
        S_COLLECT: begin
          if (rx_valid) begin
            if (rx_data == TERM_CHAR) begin
              r_state <= S_LOAD;
            end else if (w_store) begin
              r_wr_ptr <= r_wr_ptr + c_ONE;
              line_len <= r_wr_ptr + c_ONE;
            end else if (!w_is_cr) begin
              overflow <= 1'b1;
            end
          end else if (w_timeout) begin
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (r_wr_ptr != '0) begin
            r_rd_ptr <= c_ONE;
            tx_valid <= 1'b1;
            r_state  <= S_SEND;
          end else if (APPEND_CRLF) begin
            tx_valid <= 1'b1;
            r_state  <= S_CR;
          end else begin
            r_state <= S_COLLECT;
          end
        end
        S_SEND: begin
          if (w_xfer) begin
            if (!w_last_payload) begin
              r_rd_ptr <= r_rd_ptr + c_ONE;
            end else if (APPEND_CRLF) begin
              r_state <= S_CR;
            end else begin
              tx_valid <= 1'b0;
              r_wr_ptr <= '0;
              r_rd_ptr <= '0;
              r_state  <= S_COLLECT;
            end
          end
        end
        S_CR: begin
          if (w_xfer) r_state <= S_LF;
        end
        S_LF: begin
          if (w_xfer) begin
            tx_valid <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_state  <= S_COLLECT;
          end
        end
        default: begin
          tx_valid <= 1'b0;
          r_state  <= S_COLLECT;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_line_echo.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_line_echo
// Brief   : Directed, table-driven bench for uart_line_echo.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_line_echo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx_ready = 1'b1;

  // Instance A: small buffer, timeout enabled, CR/LF appended.
  logic [7:0] a_tx_data, a_last;
  logic       a_tx_valid, a_busy, a_done, a_ovf, a_drop;
  logic [2:0] a_len;
  // Instance B: defaults except no CR/LF appended.
  logic [7:0] b_tx_data, b_last;
  logic       b_tx_valid, b_busy, b_done, b_ovf, b_drop;
  logic [7:0] b_len;

  uart_line_echo #(.MAX_LEN(4), .TIMEOUT_CYCLES(100)) u_a (
    .sys_clk(clk), .sys_rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(tx_ready),
    .last_rx_byte(a_last), .line_len(a_len), .busy(a_busy),
    .line_done(a_done), .overflow(a_ovf), .rx_drop(a_drop));

  uart_line_echo #(.APPEND_CRLF(1'b0)) u_b (
    .sys_clk(clk), .sys_rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(tx_ready),
    .last_rx_byte(b_last), .line_len(b_len), .busy(b_busy),
    .line_done(b_done), .overflow(b_ovf), .rx_drop(b_drop));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observed traffic, sampled on the falling edge.
  logic [63:0] acc = '0;
  logic [7:0]  ld_byte = 8'h00;
  int tx_cnt = 0, ld_cnt = 0, ovf_cnt = 0, drop_cnt = 0, b_tx_cnt = 0, b_ld_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (a_tx_valid && tx_ready) begin
        acc = {acc[55:0], a_tx_data};
        tx_cnt++;
      end
      if (a_done) begin
        ld_cnt++;
        ld_byte = a_tx_data;
      end
      if (a_ovf)  ovf_cnt++;
      if (a_drop) drop_cnt++;
      if (b_tx_valid && tx_ready) b_tx_cnt++;
      if (b_done) b_ld_cnt++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(input int l0);
    for (int k = 0; k < 64 && ld_cnt == l0; k++) step();
    check("line_done_count", 64'(ld_cnt - l0), 64'd1);
  endtask

  // Compares the last n transmitted bytes against exp (right-aligned).
  task automatic check_tx(input string name, input int t0, input logic [63:0] exp, input int n);
    logic [63:0] mask;
    mask = (64'h1 << (8 * n)) - 64'h1;
    check({name, "_count"}, 64'(tx_cnt - t0), 64'(n));
    check({name, "_bytes"}, acc & mask, exp & mask);
  endtask

  typedef struct {
    logic [63:0] rx;
    int          rx_n;
    logic [63:0] tx;
    int          tx_n;
    int          len;
    int          ovf;
  } vec_t;

  vec_t vec [5];

  initial begin
    int t0, l0, o0, d0, bad;

    vec[0] = '{64'h41_42_0A,          3, 64'h41_42_0D_0A,          4, 2, 0};
    vec[1] = '{64'h41_0D_0A,          3, 64'h41_0D_0A,             3, 1, 0};
    vec[2] = '{64'h0A,                1, 64'h0D_0A,                2, 1, 0};
    vec[3] = '{64'h41_42_43_44_45_46_0A, 7, 64'h41_42_43_44_0D_0A, 6, 4, 2};
    vec[4] = '{64'h68_69_0D_0D_0A,    5, 64'h68_69_0D_0A,          4, 2, 0};

    step();
    step();
    check("reset_tx_valid", 64'(a_tx_valid), 64'd0);
    check("reset_tx_data",  64'(a_tx_data),  64'h00);
    check("reset_busy",     64'(a_busy),     64'd0);
    check("reset_line_len", 64'(a_len),      64'd0);
    check("reset_last_rx",  64'(a_last),     64'h00);
    rst = 1'b0;
    step();

    for (int v = 0; v < 5; v++) begin
      t0 = tx_cnt; l0 = ld_cnt; o0 = ovf_cnt;
      for (int i = 0; i < vec[v].rx_n; i++)
        send_byte(vec[v].rx[8 * (vec[v].rx_n - 1 - i) +: 8]);
      check("latency_n1_idle", 64'(a_tx_valid), 64'd0);
      step();
      check("latency_n2_valid", 64'(a_tx_valid), 64'd1);
      wait_done(l0);
      check("done_on_lf",       64'(ld_byte), 64'h0A);
      check("after_tx_valid",   64'(a_tx_valid), 64'd0);
      check("after_busy",       64'(a_busy), 64'd0);
      check_tx("vec_tx", t0, vec[v].tx, vec[v].tx_n);
      check("vec_line_len",     64'(a_len), 64'(vec[v].len));
      check("vec_overflow",     64'(ovf_cnt - o0), 64'(vec[v].ovf));
    end
    step();
    // Without CR/LF a lone terminator yields nothing: 4 non-empty lines, 2+1+6+2 bytes.
    check("noappend_lines", 64'(b_ld_cnt), 64'd4);
    check("noappend_bytes", 64'(b_tx_cnt), 64'd11);

    // Backpressure on the second payload byte.
    t0 = tx_cnt; l0 = ld_cnt;
    send_byte(8'h41); send_byte(8'h42); send_byte(8'h43); send_byte(8'h0A);
    step();
    step();
    tx_ready = 1'b0;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (a_tx_valid !== 1'b1 || a_tx_data !== 8'h42) bad++;
      step();
    end
    check("stall_hold", 64'(bad), 64'd0);
    tx_ready = 1'b1;
    wait_done(l0);
    check_tx("stall_tx", t0, 64'h41_42_43_0D_0A, 5);

    // Idle timeout on a non-empty line.
    t0 = tx_cnt; l0 = ld_cnt;
    send_byte(8'h58); send_byte(8'h59);
    bad = 0;
    for (int k = 0; k < 101; k++) begin
      if (a_tx_valid !== 1'b0) bad++;
      step();
    end
    check("timeout_not_early", 64'(bad), 64'd0);
    check("timeout_fires",     64'(a_tx_valid), 64'd1);
    wait_done(l0);
    check_tx("timeout_tx", t0, 64'h58_59_0D_0A, 4);
    t0 = tx_cnt;
    repeat (300) step();
    check("idle_empty_no_tx", 64'(tx_cnt - t0), 64'd0);
    check("idle_empty_busy",  64'(a_busy), 64'd0);

    // Byte arriving mid-echo is dropped without disturbing the echo.
    t0 = tx_cnt; l0 = ld_cnt; d0 = drop_cnt;
    send_byte(8'h41); send_byte(8'h42); send_byte(8'h43); send_byte(8'h0A);
    step();
    send_byte(8'h51);
    check("drop_last_rx", 64'(a_last), 64'h51);
    wait_done(l0);
    check("drop_pulse", 64'(drop_cnt - d0), 64'd1);
    check_tx("drop_tx", t0, 64'h41_42_43_0D_0A, 5);

    // Reset in the middle of SEND aborts immediately.
    send_byte(8'h41); send_byte(8'h42); send_byte(8'h43); send_byte(8'h0A);
    tx_ready = 1'b0;
    step();
    check("pre_rst_valid", 64'(a_tx_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_async_valid", 64'(a_tx_valid), 64'd0);
    check("rst_busy",        64'(a_busy), 64'd0);
    step();
    rst = 1'b0;
    tx_ready = 1'b1;
    step();
    t0 = tx_cnt; l0 = ld_cnt;
    send_byte(8'h5A); send_byte(8'h0A);
    wait_done(l0);
    check_tx("post_rst_tx", t0, 64'h5A_0D_0A, 3);
    check("post_rst_len", 64'(a_len), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
